// File: rtl/x_ramb4_s4_stream_reader_if.sv
// Pin bundle between the stream reader, the RAM B-side port and the downstream consumer.
// slave = reader engine view; master = surrounding environment view.
interface x_ramb4_s4_stream_reader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4,
  parameter int LEN_W  = 11
);
  logic              CMD_VALID;
  logic              CMD_READY;
  logic [ADDR_W-1:0] CMD_ADDR;
  logic [LEN_W-1:0]  CMD_LEN;
  logic              RAM_EN;
  logic              RAM_WE;
  logic              RAM_RST;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic [DATA_W-1:0] RAM_DO;
  logic              DOUT_VALID;
  logic              DOUT_READY;
  logic [DATA_W-1:0] DOUT;
  logic              DOUT_LAST;
  logic              BUSY;
  logic              ERR;

  modport slave (
    input  CMD_VALID, CMD_ADDR, CMD_LEN, RAM_DO, DOUT_READY,
    output CMD_READY, RAM_EN, RAM_WE, RAM_RST, RAM_ADDR,
           DOUT_VALID, DOUT, DOUT_LAST, BUSY, ERR
  );

  modport master (
    output CMD_VALID, CMD_ADDR, CMD_LEN, RAM_DO, DOUT_READY,
    input  CMD_READY, RAM_EN, RAM_WE, RAM_RST, RAM_ADDR,
           DOUT_VALID, DOUT, DOUT_LAST, BUSY, ERR
  );
endinterface

// File: rtl/x_ramb4_s4_stream_reader.sv
// Sequential read engine for the 4-bit port of a 1024x4 block RAM; streams nibbles with a last marker.
// Define X_RAMB4_STREAM_READER_WRAP_EN to let a command wrap from word 1023 back to word 0.
module x_ramb4_s4_stream_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4,
  parameter int LEN_W  = 11
) (
  input logic CLKA,
  input logic RSTB,
  x_ramb4_s4_stream_reader_if.slave bus
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int FIFO_D = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } ent_t;

  state_t            state, state_nxt;
  logic              ready_en;
  logic              err;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic              inflight, inflight_last;
  ent_t              fifo [FIFO_D];
  logic [1:0]        wr_ptr, rd_ptr;
  logic [2:0]        count;

  logic       cmd_ready, accept, len_ok, legal;
  logic       issue, push, pop, fifo_vld, last_pop;
  logic [3:0] credit_used;

  assign accept = bus.CMD_VALID & cmd_ready;
  assign len_ok = (bus.CMD_LEN != '0) && (bus.CMD_LEN <= LEN_W'(DEPTH));

`ifdef X_RAMB4_STREAM_READER_WRAP_EN
  assign legal = len_ok;
`else
  // Without wrap, a command must end at or before the top of the RAM.
  logic [LEN_W:0] end_addr;
  assign end_addr = (LEN_W+1)'(bus.CMD_ADDR) + (LEN_W+1)'(bus.CMD_LEN);
  assign legal    = len_ok && (end_addr <= (LEN_W+1)'(DEPTH));
`endif

  // Slots already promised: stored words plus the read whose data lands next cycle.
  assign credit_used = 4'(count) + 4'(inflight);
  assign fifo_vld    = (count != 3'd0);
  assign push        = inflight;
  assign pop         = fifo_vld & bus.DOUT_READY;
  assign last_pop    = pop & fifo[rd_ptr].last;

  // State register
  always_ff @(posedge CLKA) begin
    if (RSTB) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && legal) state_nxt = RUN;
      RUN:     if (issue && remaining == LEN_W'(1)) state_nxt = DRAIN;
      DRAIN:   if (last_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cmd_ready = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE:    cmd_ready = ready_en;
      RUN:     issue = (remaining != '0) && (credit_used < 4'(FIFO_D));
      default: ;
    endcase
  end

  // Command registers, read issue and the RAM latency stage
  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      ready_en      <= 1'b0;
      err           <= 1'b0;
      addr          <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      err      <= accept & ~legal;
      if (accept && legal) begin
        addr      <= bus.CMD_ADDR;
        remaining <= bus.CMD_LEN;
      end else if (issue) begin
        addr      <= addr + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
      end
      inflight      <= issue;
      inflight_last <= issue && (remaining == LEN_W'(1));
    end
  end

  // Skid FIFO; the credit check guarantees a push never meets a full FIFO
  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      for (int i = 0; i < FIFO_D; i++) fifo[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= '{last: inflight_last, data: bus.RAM_DO};
        wr_ptr       <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.CMD_READY  = cmd_ready;
  assign bus.RAM_EN     = issue;
  assign bus.RAM_WE     = 1'b0;
  assign bus.RAM_RST    = 1'b0;
  assign bus.RAM_ADDR   = addr;
  assign bus.DOUT_VALID = fifo_vld;
  assign bus.DOUT       = fifo[rd_ptr].data;
  assign bus.DOUT_LAST  = fifo_vld & fifo[rd_ptr].last;
  assign bus.BUSY       = (state != IDLE);
  assign bus.ERR        = err;

endmodule

// File: tb/tb_x_ramb4_s4_stream_reader.sv
// Directed bench for the stream reader; RAM model holds n[3:0] at word n.
module tb_x_ramb4_s4_stream_reader;
  logic CLKA = 1'b0;
  logic RSTB = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   en_cnt = 0;
  int   q_data[$];
  int   q_last[$];
  int   q_cyc[$];
  logic [3:0] mem [1024];
  logic [3:0] ram_q = 4'd0;

  x_ramb4_s4_stream_reader_if bus ();
  x_ramb4_s4_stream_reader dut (.CLKA(CLKA), .RSTB(RSTB), .bus(bus));

  always #5 CLKA = ~CLKA;

  initial for (int i = 0; i < 1024; i++) mem[i] = 4'(i);

  always @(posedge CLKA) begin
    cyc <= cyc + 1;
    if (bus.RAM_EN) ram_q <= mem[bus.RAM_ADDR];
  end
  assign bus.RAM_DO = ram_q;

  // Record every read strobe and every accepted output word with its cycle
  always @(negedge CLKA) begin
    if (bus.RAM_EN) en_cnt <= en_cnt + 1;
    if (bus.DOUT_VALID && bus.DOUT_READY) begin
      q_data.push_back(int'(bus.DOUT));
      q_last.push_back(int'(bus.DOUT_LAST));
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic at_neg(input int t);
    @(negedge CLKA);
    while (cyc < t) @(negedge CLKA);
  endtask

  task automatic clear_q();
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
  endtask

  task automatic send_cmd(input int a, input int l, output int t);
    @(posedge CLKA); #1;
    bus.CMD_VALID = 1'b1;
    bus.CMD_ADDR  = 10'(a);
    bus.CMD_LEN   = 11'(l);
    t = cyc;
    @(negedge CLKA);
    chk("cmd_ready_at_offer", int'(bus.CMD_READY), 1);
    @(posedge CLKA); #1;
    bus.CMD_VALID = 1'b0;
  endtask

  // t_first < 0 skips the per-word timing check
  task automatic chk_stream(input string tag, input int a, input int n, input int t_first);
    chk({tag, "_count"}, q_data.size(), n);
    if (q_data.size() == n) begin
      for (int i = 0; i < n; i++) begin
        chk($sformatf("%s_data%0d", tag, i), q_data[i], (a + i) % 16);
        chk($sformatf("%s_last%0d", tag, i), q_last[i], (i == n - 1) ? 1 : 0);
        if (t_first >= 0) chk($sformatf("%s_cyc%0d", tag, i), q_cyc[i], t_first + i);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int e0;
    int lens[2];
    lens[0] = 0;
    lens[1] = 1025;
    bus.CMD_VALID  = 1'b0;
    bus.CMD_ADDR   = '0;
    bus.CMD_LEN    = '0;
    bus.DOUT_READY = 1'b1;

    // Reset state and release timing
    repeat (3) @(posedge CLKA);
    @(negedge CLKA);
    chk("rst_cmd_ready", int'(bus.CMD_READY), 0);
    chk("rst_busy", int'(bus.BUSY), 0);
    chk("rst_dout_valid", int'(bus.DOUT_VALID), 0);
    chk("rst_ram_en", int'(bus.RAM_EN), 0);
    chk("rst_err", int'(bus.ERR), 0);
    chk("rst_dout_last", int'(bus.DOUT_LAST), 0);
    chk("ram_we", int'(bus.RAM_WE), 0);
    chk("ram_rst", int'(bus.RAM_RST), 0);
    @(posedge CLKA); #1;
    RSTB = 1'b0;
    @(negedge CLKA);
    chk("ready_first_cycle_after_rst", int'(bus.CMD_READY), 0);
    @(negedge CLKA);
    chk("ready_second_cycle_after_rst", int'(bus.CMD_READY), 1);

    // ADDR=5 LEN=3, consumer always ready
    clear_q();
    e0 = en_cnt;
    send_cmd(5, 3, t);
    at_neg(t + 1);
    chk("t1_busy_t1", int'(bus.BUSY), 1);
    chk("t1_ram_en_t1", int'(bus.RAM_EN), 1);
    chk("t1_ram_addr_t1", int'(bus.RAM_ADDR), 5);
    at_neg(t + 2);
    chk("t1_valid_t2", int'(bus.DOUT_VALID), 0);
    at_neg(t + 6);
    chk("t1_busy_t6", int'(bus.BUSY), 0);
    chk("t1_ready_t6", int'(bus.CMD_READY), 1);
    chk("t1_reads", en_cnt - e0, 3);
    chk_stream("t1", 5, 3, t + 3);

    // ADDR=0 LEN=16 with the consumer stalled for T+3..T+10
    bus.DOUT_READY = 1'b0;
    clear_q();
    e0 = en_cnt;
    send_cmd(0, 16, t);
    at_neg(t + 3);
    chk("t2_valid_t3", int'(bus.DOUT_VALID), 1);
    chk("t2_dout_t3", int'(bus.DOUT), 0);
    at_neg(t + 10);
    chk("t2_reads_during_stall", en_cnt - e0, 4);
    chk("t2_valid_t10", int'(bus.DOUT_VALID), 1);
    chk("t2_dout_t10", int'(bus.DOUT), 0);
    chk("t2_last_t10", int'(bus.DOUT_LAST), 0);
    chk("t2_no_pops_in_stall", q_data.size(), 0);
    @(posedge CLKA); #1;
    bus.DOUT_READY = 1'b1;
    at_neg(t + 40);
    chk_stream("t2", 0, 16, -1);
    chk("t2_reads_total", en_cnt - e0, 16);
    chk("t2_busy_end", int'(bus.BUSY), 0);

    // Illegal lengths
    foreach (lens[k]) begin
      clear_q();
      e0 = en_cnt;
      send_cmd(0, lens[k], t);
      at_neg(t + 1);
      chk($sformatf("bad_len%0d_err_t1", lens[k]), int'(bus.ERR), 1);
      chk($sformatf("bad_len%0d_ready", lens[k]), int'(bus.CMD_READY), 1);
      chk($sformatf("bad_len%0d_busy", lens[k]), int'(bus.BUSY), 0);
      at_neg(t + 2);
      chk($sformatf("bad_len%0d_err_t2", lens[k]), int'(bus.ERR), 0);
      at_neg(t + 5);
      chk($sformatf("bad_len%0d_reads", lens[k]), en_cnt - e0, 0);
      chk($sformatf("bad_len%0d_words", lens[k]), q_data.size(), 0);
    end

    // Crossing the top of the RAM
    clear_q();
    e0 = en_cnt;
    send_cmd(1022, 4, t);
`ifdef X_RAMB4_STREAM_READER_WRAP_EN
    at_neg(t + 10);
    chk_stream("wrap", 1022, 4, t + 3);
    chk("wrap_reads", en_cnt - e0, 4);
`else
    at_neg(t + 1);
    chk("nowrap_err_t1", int'(bus.ERR), 1);
    chk("nowrap_ready", int'(bus.CMD_READY), 1);
    at_neg(t + 2);
    chk("nowrap_err_t2", int'(bus.ERR), 0);
    at_neg(t + 6);
    chk("nowrap_reads", en_cnt - e0, 0);
    chk("nowrap_words", q_data.size(), 0);
`endif

    // Command ending exactly at the top word is legal either way
    clear_q();
    send_cmd(1020, 4, t);
    at_neg(t + 1);
    chk("edge_err", int'(bus.ERR), 0);
    at_neg(t + 10);
    chk_stream("edge", 1020, 4, t + 3);

    // Reset in the middle of an ADDR=0 LEN=8 command
    send_cmd(0, 8, t);
    at_neg(t + 3);
    @(posedge CLKA); #1;
    RSTB = 1'b1;
    at_neg(t + 5);
    chk("midrst_valid", int'(bus.DOUT_VALID), 0);
    chk("midrst_ram_en", int'(bus.RAM_EN), 0);
    chk("midrst_busy", int'(bus.BUSY), 0);
    chk("midrst_ready", int'(bus.CMD_READY), 0);
    @(posedge CLKA); #1;
    RSTB = 1'b0;
    @(negedge CLKA);
    chk("midrst_ready_hold", int'(bus.CMD_READY), 0);
    chk("midrst_valid_hold", int'(bus.DOUT_VALID), 0);
    @(negedge CLKA);
    chk("midrst_ready_back", int'(bus.CMD_READY), 1);
    clear_q();
    send_cmd(3, 1, t);
    at_neg(t + 6);
    chk_stream("post_rst", 3, 1, t + 3);
    chk("post_rst_busy", int'(bus.BUSY), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/x_ramb4_s4_stream_reader.md
# x_ramb4_s4_stream_reader

Read-side engine for a 1024 x 4 block-RAM port (the 4-bit port of a S1/S4 dual-port RAM). It accepts a start-address/length command and issues sequential reads. It absorbs the RAM's one-cycle registered read latency in a 4-entry skid FIFO and delivers the nibbles on a valid/ready stream with a last-word marker. It sits between the RAM's B-side pins and downstream stream consumers, while the 1-bit side is written independently.

## Interface
Parameters:
- ADDR_W, 10, RAM word address width (1024 nibbles).
- DATA_W, 4, RAM/stream data width.
- LEN_W, 11, command length width; legal lengths are 1..1024.

Ports:
- CLKA  in  1  clock for all logic and the RAM port.
- RSTB  in  1  reset, synchronous, active-high.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  engine idle; command accepted when VALID & READY.
- CMD_ADDR  in  ADDR_W  first word address.
- CMD_LEN  in  LEN_W  number of words.
- RAM_EN  out  1  RAM port enable (read strobe).
- RAM_WE  out  1  constant 0.
- RAM_RST  out  1  constant 0.
- RAM_ADDR  out  ADDR_W  RAM address.
- RAM_DO  in  DATA_W  RAM registered read data.
- DOUT_VALID  out  1  stream word available.
- DOUT_READY  in  1  consumer accepts.
- DOUT  out  DATA_W  stream data.
- DOUT_LAST  out  1  final word of the command, qualified by DOUT_VALID.
- BUSY  out  1  command in progress.
- ERR  out  1  one-cycle pulse when an illegal command is rejected.

## Operation
- The engine has three states:
  - IDLE: CMD_READY=1. On accept, a legal command latches addr/len and moves to RUN. An illegal command pulses ERR next cycle and stays in IDLE.
  - RUN: issues reads until all words are issued, then moves to DRAIN.
  - DRAIN: waits for the FIFO and in-flight reads to empty and the LAST word to be popped, then returns to IDLE.
- A command is illegal if LEN=0 or LEN>1024. The extra rule in Configuration applies when the macro is absent.
- Read issue: RAM_EN=1 in a cycle only if state=RUN, remaining>0, and fifo_count + inflight < 4. Both values are registered.
  - Each issue increments RAM_ADDR modulo 1024 and decrements remaining.
- inflight is a 1-bit register set on issue. In the following cycle RAM_DO is written into the FIFO.
- The FIFO is 4 entries, registered storage. DOUT is the head entry. A pop occurs on DOUT_VALID & DOUT_READY.
  - A simultaneous push and pop in the same cycle leaves the count unchanged.
- Each FIFO entry carries a last flag, set on the word whose issue brought remaining to 0.
- BUSY=1 from the cycle after accept until the cycle after the LAST pop.
- Stall: while DOUT_READY=0, DOUT and DOUT_LAST stay stable and DOUT_VALID stays high. Issue stops once the credit limit is reached. No words are lost or duplicated.

## Timing
- Reset: while RSTB=1 and in the cycle following, all outputs are 0, including CMD_READY. The FIFO and inflight are cleared.
- CMD_READY=1 from the second cycle after RSTB deasserts.
- Reset asserted mid-command: the next cycle is in IDLE-reset state, RAM_EN=0, the FIFO is flushed, and in-flight data is discarded.
- Latency: command accepted in cycle T gives RAM_EN=1 at T+1 and RAM_DO captured at the end of T+2. DOUT_VALID=1 at T+3.
- Throughput: with DOUT_READY held high, one word per cycle; N words complete by cycle T+2+N.
- Back-to-back commands: the next CMD_READY rises the cycle after the LAST pop.
- ERR is high for exactly one cycle, T+1, after an illegal accept.

## Configuration
- Macro X_RAMB4_STREAM_READER_WRAP_EN.
- Defined: the address wraps 1023→0 within a command. ADDR=1022 with LEN=4 reads 1022, 1023, 0, 1.
- Undefined: a command with CMD_ADDR+CMD_LEN>1024 is illegal and triggers ERR with no RAM access. Wrap logic is absent.

## Test plan
RAM model preloaded so that word n holds n[3:0] (INIT pattern 0x…FEDCBA9876543210 repeating).
- Command ADDR=5, LEN=3, DOUT_READY=1.
  - Response: DOUT 5,6,7 in cycles T+3..T+5, LAST only on 7, BUSY low at T+6.
- Command ADDR=0, LEN=16; DOUT_READY low for cycles T+3..T+10, then high.
  - Response: at most 4 RAM_EN pulses during the stall, output 0..F in order, no duplicates.
- Command LEN=0, then LEN=1025.
  - Response: each gives one ERR pulse at T+1, no RAM_EN, and CMD_READY stays 1.
- Command ADDR=1022, LEN=4.
  - With the macro: output E,F,0,1.
  - Without the macro: ERR pulse, no reads.
- RSTB asserted at T+4 of an ADDR=0, LEN=8 command.
  - Response: next cycle DOUT_VALID=0, RAM_EN=0, BUSY=0.
  - A new command ADDR=3, LEN=1 afterwards returns 3 with LAST.
